ds_integrator: RTL and testbench

Saturating discrete-time integrator stage for the delta-sigma modulator loop filter. It consumes the 41-bit signed, coefficient-scaled sample produced by the upstream constant-shift-add multiplier stage (the c4 0.5713 gain). It adds that sample to its state and subtracts the 1-bit quantizer feedback, scaled to a DAC level. The registered state feeds the next coefficient stage or the quantizer. A warm-up counter suppresses feedback for the first few samples after reset or clear.

---
 rtl/ds_integrator.sv | 95 +++++++++
 tb/tb_ds_integrator.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ds_integrator.sv
// Saturating loop-filter integrator: y += x - fb, clamped to W-bit signed range.
// One-cycle latency per accepted sample; quantizer feedback is held at zero for SETTLE samples after reset/clear.
module ds_integrator #(
  parameter int W        = 41,
  parameter int FB_SHIFT = 36,
  parameter int SETTLE   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic signed [W-1:0] x,
  input  logic                fb_bit,
  output logic signed [W-1:0] y,
  output logic                y_vld,
  output logic                sat,
  output logic                ovf,
  output logic                settled
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] LAST = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;

  // Two guard bits cover y + x + DAC without any intermediate wrap.
  localparam logic signed [W+1:0] DAC     = (W+2)'(1) << FB_SHIFT;
  localparam logic signed [W+1:0] MAX_EXT = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MIN_EXT = {3'b111, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_Y   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_Y   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {ST_SETTLE, ST_RUN} state_t;
  localparam state_t ST_INIT = (SETTLE == 0) ? ST_RUN : ST_SETTLE;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  logic signed [W+1:0] y_ext, x_ext, fb, sum;
  logic signed [W-1:0] y_nxt;
  logic                sat_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (en && state == ST_SETTLE) begin
      cnt_nxt = cnt + CW'(1);
      if (cnt == LAST) state_nxt = ST_RUN;
    end
  end

  always_comb begin
    y_ext   = {{2{y[W-1]}}, y};
    x_ext   = {{2{x[W-1]}}, x};
    fb      = '0;
    if (state == ST_RUN) fb = fb_bit ? DAC : -DAC;
    sum     = y_ext + x_ext - fb;
    y_nxt   = sum[W-1:0];
    sat_nxt = 1'b0;
    if (sum > MAX_EXT) begin
      y_nxt   = MAX_Y;
      sat_nxt = 1'b1;
    end else if (sum < MIN_EXT) begin
      y_nxt   = MIN_Y;
      sat_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      y       <= '0;
      y_vld   <= 1'b0;
      sat     <= 1'b0;
      ovf     <= 1'b0;
      settled <= (SETTLE == 0);
    end else begin
      y_vld <= en;
      if (en) begin
        y       <= y_nxt;
        sat     <= sat_nxt;
        ovf     <= ovf | sat_nxt;
        settled <= (state_nxt == ST_RUN);
      end
    end
  end

endmodule

// File: tb/tb_ds_integrator.sv
// Directed bench: default build (FB_SHIFT=36, SETTLE=4) and a FB_SHIFT=3, SETTLE=0 build share stimulus.
module tb_ds_integrator;

  logic               clk = 1'b0;
  logic               rst_n, en, clr, fb_bit;
  logic signed [40:0] x;
  logic signed [40:0] y, y2;
  logic               y_vld, sat, ovf, settled;
  logic               y_vld2, sat2, ovf2, settled2;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  ds_integrator #(.W(41), .FB_SHIFT(36), .SETTLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x), .fb_bit(fb_bit),
    .y(y), .y_vld(y_vld), .sat(sat), .ovf(ovf), .settled(settled)
  );

  ds_integrator #(.W(41), .FB_SHIFT(3), .SETTLE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x), .fb_bit(fb_bit),
    .y(y2), .y_vld(y_vld2), .sat(sat2), .ovf(ovf2), .settled(settled2)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic signed [63:0] xv, input logic fb);
    en     = e;
    x      = xv[40:0];
    fb_bit = fb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic signed [63:0] ey, input logic ev,
                          input logic es, input logic eo, input logic est);
    chk({tag, ".y"}, y, ey);
    chk({tag, ".y_vld"}, y_vld, ev);
    chk({tag, ".sat"}, sat, es);
    chk({tag, ".ovf"}, ovf, eo);
    chk({tag, ".settled"}, settled, est);
  endtask

  localparam logic signed [63:0] P36 = 64'sd1 <<< 36;
  localparam logic signed [63:0] P37 = 64'sd1 <<< 37;
  localparam logic signed [63:0] P39 = 64'sd1 <<< 39;
  localparam logic signed [63:0] P40 = 64'sd1 <<< 40;

  logic signed [63:0] warm [6];

  initial begin
    warm[0] = 1000; warm[1] = 2000; warm[2] = 3000; warm[3] = 4000;
    warm[4] = 5000 - P36; warm[5] = 6000 - P37;

    rst_n = 1'b0; clr = 1'b0;
    drive(1'b0, 0, 1'b0);
    tick();
    chk_main("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.settled2", settled2, 1'b1);
    chk("reset.y2", y2, 0);

    // Warm-up: no feedback for four samples, then fb_bit=1 subtracts 2^36.
    rst_n = 1'b1;
    drive(1'b1, 1000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_main($sformatf("warm%0d", i), warm[i], 1'b1, 1'b0, 1'b0, i >= 3);
    end

    drive(1'b1, P40 - 1, 1'b0);
    tick();
    chk_main("pos0", P40 - 1 + 6000 - P36, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_main("pos1", P40 - 1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, -P39, 1'b1);
    tick();
    chk_main("pos2", P40 - 1 - P39 - P36, 1'b1, 1'b0, 1'b1, 1'b1);

    // Bring y back to exactly zero, then drive hard negative.
    drive(1'b1, -P39 + P37 + 1, 1'b1);
    tick();
    chk_main("zero", 0, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, -P40, 1'b1);
    tick();
    chk_main("neg0", -P40, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, -P40, 1'b0);
    tick();
    chk_main("neg1", -P40, 1'b1, 1'b1, 1'b1, 1'b1);

    drive(1'b0, 12345, 1'b1);
    tick();
    chk_main("hold", -P40, 1'b0, 1'b1, 1'b1, 1'b1);

    clr = 1'b1;
    drive(1'b1, 5, 1'b1);
    tick();
    chk_main("clr", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    drive(1'b1, 100, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_main($sformatf("postclr%0d", i), 100 * i, 1'b1, 1'b0, 1'b0, i == 4);
    end
    tick();
    chk_main("postclr5", 500 - P36, 1'b1, 1'b0, 1'b0, 1'b1);

    rst_n = 1'b0;
    tick();
    chk_main("rstmid", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstmid.y2", y2, 0);
    chk("rstmid.ovf2", ovf2, 1'b0);
    chk("rstmid.sat2", sat2, 1'b0);
    chk("rstmid.settled2", settled2, 1'b1);

    // Enable gaps on the SETTLE=0 build: feedback applies from the first sample.
    rst_n = 1'b1;
    drive(1'b1, 7, 1'b0);
    tick();
    chk("gap0.y2", y2, 15);
    chk("gap0.vld2", y_vld2, 1'b1);
    chk("gap0.y", y, 7);
    drive(1'b0, 7, 1'b0);
    tick();
    chk("gap1.y2", y2, 15);
    chk("gap1.vld2", y_vld2, 1'b0);
    drive(1'b1, 7, 1'b0);
    tick();
    chk("gap2.y2", y2, 30);
    chk("gap2.vld2", y_vld2, 1'b1);
    drive(1'b0, 7, 1'b0);
    tick();
    chk("gap3.y2", y2, 30);
    chk("gap3.vld2", y_vld2, 1'b0);
    chk("gap3.y", y, 14);
    chk("gap3.settled", settled, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
